// File: rtl/instr_cache_l1_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared types, width helpers and parameter legality for the L1 I$.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam int c_INSTR_W = 32;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_w, input int sets);
    return 32 - off_w(line_w) - idx_w(sets);
  endfunction

  function automatic bit params_ok(input int line_w, input int sets, input int ways);
    return (line_w inside {64, 128, 256, 512}) &&
           (sets >= 2) && (sets <= 1024) && ((sets & (sets - 1)) == 0) &&
           (ways inside {1, 2, 4});
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_cache_l1_assoc_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_l1_assoc_if
// Purpose  : Line-refill request/valid bus between the I$ and the memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_cache_l1_assoc_if #(
  parameter int LINE_W = 256
) ();

  logic              mem_req;
  logic [31:0]       mem_address;
  logic [LINE_W-1:0] mem_data;
  logic              mem_valid;

  modport master (
    output mem_req,
    output mem_address,
    input  mem_data,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_address,
    output mem_data,
    output mem_valid
  );

endinterface
`default_nettype wire

// File: rtl/instr_cache_l1_assoc_way_store.sv
`default_nettype none
// ============================================================================
// Module   : icache_way_store
// Purpose  : One way of valid/tag/line flops, async read, single write port.
// Revision : 1.0 - initial release
// ============================================================================
module icache_way_store
  import icache_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int SETS   = 1024
) (
  input  wire logic                          CLK,
  input  wire logic                          RESET,
  input  wire logic [idx_w(SETS)-1:0]        i_rd_index,
  output logic                               o_rd_valid,
  output logic [tag_w(LINE_W, SETS)-1:0]     o_rd_tag,
  output logic [LINE_W-1:0]                  o_rd_line,
  input  wire logic                          i_we,
  input  wire logic [idx_w(SETS)-1:0]        i_wr_index,
  input  wire logic [tag_w(LINE_W, SETS)-1:0] i_wr_tag,
  input  wire logic [LINE_W-1:0]             i_wr_line,
  input  wire logic                          i_flush_clr
);

  localparam int c_TAG_W = tag_w(LINE_W, SETS);

  logic [SETS-1:0]    r_valid;
  logic [c_TAG_W-1:0] r_tag  [SETS];
  logic [LINE_W-1:0]  r_line [SETS];

  // Only valid bits are reset/flushed; stale tags and data are masked by them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid <= '0;
    end else if (i_flush_clr) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_line[i_wr_index] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_line[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/instr_cache_l1_assoc.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_l1_assoc
// Purpose  : Set-associative L1 instruction cache with round-robin refill.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cache_l1_assoc
  import icache_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int SETS   = 1024,
  parameter int WAYS   = 2
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  input  wire logic        fetch_valid,
  input  wire logic [31:0] instr_addressIF,
  input  wire logic        flush,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic             hit,
  output logic             stall,
  instr_cache_l1_assoc_if.master mem
);

  localparam int c_OFF_W  = off_w(LINE_W);
  localparam int c_IDX_W  = idx_w(SETS);
  localparam int c_TAG_W  = tag_w(LINE_W, SETS);
  localparam int c_WORD_W = c_OFF_W - 2;
  localparam int c_WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (!params_ok(LINE_W, SETS, WAYS)) begin : g_param_check
    $error("instr_cache_l1_assoc: illegal LINE_W/SETS/WAYS combination");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic [c_TAG_W-1:0]  w_tag;
  logic [c_IDX_W-1:0]  w_idx;
  logic [c_WORD_W-1:0] w_word;
  logic                w_unused_addr_lsb;

  logic [WAYS-1:0]     w_rd_valid;
  logic [c_TAG_W-1:0]  w_rd_tag  [WAYS];
  logic [LINE_W-1:0]   w_rd_line [WAYS];
  logic [WAYS-1:0]     w_we;
  logic [WAYS-1:0]     w_match;
  logic [31:0]         w_hit_word;

  logic                w_lookup_hit;
  logic                w_miss;
  logic                w_flush_clr;
  logic                w_rr_adv;
  logic [c_WAY_W-1:0]  w_rr_cur;
  logic [c_WAY_W-1:0]  w_victim;
  logic                w_victim_repl;

  logic                r_mem_req;
  logic [31:0]         r_mem_addr;
  logic [c_TAG_W-1:0]  r_miss_tag;
  logic [c_IDX_W-1:0]  r_miss_idx;
  logic [c_WAY_W-1:0]  r_victim;
  logic                r_victim_repl;
  logic                r_flush_pend;

  assign w_tag             = instr_addressIF[31 -: c_TAG_W];
  assign w_idx             = instr_addressIF[c_OFF_W +: c_IDX_W];
  assign w_word            = instr_addressIF[2 +: c_WORD_W];
  assign w_unused_addr_lsb = ^instr_addressIF[1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way_store #(
      .LINE_W (LINE_W),
      .SETS   (SETS)
    ) u_way (
      .CLK         (CLK),
      .RESET       (RESET),
      .i_rd_index  (w_idx),
      .o_rd_valid  (w_rd_valid[g]),
      .o_rd_tag    (w_rd_tag[g]),
      .o_rd_line   (w_rd_line[g]),
      .i_we        (w_we[g]),
      .i_wr_index  (r_miss_idx),
      .i_wr_tag    (r_miss_tag),
      .i_wr_line   (mem.mem_data),
      .i_flush_clr (w_flush_clr)
    );
    assign w_we[g] = (r_state == REQ) && mem.mem_valid && (r_victim == c_WAY_W'(g));
  end

  // At most one way matches, so OR-ing the selected words acts as the mux.
  always_comb begin
    w_match    = '0;
    w_hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = w_rd_valid[w] && (w_rd_tag[w] == w_tag);
      if (w_match[w]) begin
        w_hit_word = w_hit_word | w_rd_line[w][{w_word, 5'b0} +: 32];
      end
    end
  end

  assign w_lookup_hit = fetch_valid && (r_state == IDLE) && (|w_match);
  assign w_miss       = fetch_valid && (r_state == IDLE) && !(|w_match);
  assign hit          = w_lookup_hit;
  assign stall        = (fetch_valid && !w_lookup_hit) || (r_state != IDLE);

  // A deferred flush lands on the FILL->IDLE edge, wiping the fresh line too.
  assign w_flush_clr = ((r_state == IDLE) && flush) ||
                       ((r_state == FILL) && (r_flush_pend || flush));
  assign w_rr_adv    = (r_state == FILL) && r_victim_repl;

  if (WAYS > 1) begin : g_rr
    logic [c_WAY_W-1:0] r_rr [SETS];

    always_ff @(posedge CLK) begin
      if (!RESET || w_flush_clr) begin
        for (int s = 0; s < SETS; s++) begin
          r_rr[s] <= '0;
        end
      end else if (w_rr_adv) begin
        r_rr[r_miss_idx] <= r_rr[r_miss_idx] + 1'b1;
      end
    end

    assign w_rr_cur = r_rr[w_idx];
  end else begin : g_no_rr
    assign w_rr_cur = '0;
  end

  always_comb begin
    w_victim      = w_rr_cur;
    w_victim_repl = &w_rd_valid;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_rd_valid[w]) begin
        w_victim = c_WAY_W'(w);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_state_nxt = REQ;
      REQ:     if (mem.mem_valid) w_state_nxt = FILL;
      FILL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_miss_tag    <= '0;
      r_miss_idx    <= '0;
      r_victim      <= '0;
      r_victim_repl <= 1'b0;
      r_flush_pend  <= 1'b0;
      instr_out     <= '0;
      instr_valid   <= 1'b0;
    end else begin
      instr_valid <= w_lookup_hit;
      if (w_lookup_hit) begin
        instr_out <= w_hit_word;
      end

      if (r_state == FILL) begin
        r_flush_pend <= 1'b0;
      end else if ((r_state == REQ) && flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_miss) begin
        r_mem_req     <= 1'b1;
        r_mem_addr    <= {w_tag, w_idx, c_OFF_W'(0)};
        r_miss_tag    <= w_tag;
        r_miss_idx    <= w_idx;
        r_victim      <= w_victim;
        r_victim_repl <= w_victim_repl;
      end else if ((r_state == REQ) && mem.mem_valid) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign mem.mem_req     = r_mem_req;
  assign mem.mem_address = r_mem_addr;

endmodule
`default_nettype wire

// File: doc/instr_cache_l1_assoc.md
# instr_cache_L1_assoc

Parametrised set-associative L1 instruction cache for the IF stage. Returns one 32-bit instruction per cycle on a hit. On a miss it stalls, fetches one full line from the memory side over a req/valid handshake, and refills it with a round-robin victim. Adds associativity, a registered instruction-valid output, explicit stall, and a whole-cache flush.

## Interface
- LINE_W, 256, line width in bits; power of two, 64..512
- SETS, 1024, sets per way; power of two, 2..1024
- WAYS, 2, associativity; one of 1, 2, 4
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, synchronous, active-low
- fetch_valid  in  1  instr_addressIF is a valid fetch this cycle
- instr_addressIF  in  32  byte address, word aligned; bits [1:0] ignored
- flush  in  1  one-cycle pulse: invalidate all lines
- instr_out  out  32  registered instruction
- instr_valid  out  1  instr_out is valid this cycle
- hit  out  1  combinational: tag match on a valid way for instr_addressIF
- stall  out  1  combinational: fetch_valid & ~hit, or FSM not IDLE
- mem_req  out  1  line request, held until mem_valid
- mem_address  out  32  line-aligned byte address, low OFF_W bits zero
- mem_data  in  LINE_W  refill line, bit 0 = lowest byte of line
- mem_valid  in  1  mem_data valid; one-cycle pulse

## Operation
- Derived widths: OFF_W = log2(LINE_W/8); IDX_W = log2(SETS); TAG_W = 32 - OFF_W - IDX_W.
- Address split: tag = [31:OFF_W+IDX_W]; index = [OFF_W+IDX_W-1:OFF_W]; word = [OFF_W-1:2].
- Each entry is {valid, tag, line}; the arrays are flops with asynchronous read.
- hit = OR over ways of (valid & tag match), qualified by fetch_valid. A hit is only reported in IDLE.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - On fetch_valid & ~hit: latch miss address, set mem_req=1, mem_address={tag,index,OFF_W'b0}, go to REQ.
  - Victim is the first invalid way (lowest index). If all ways are valid, the victim is the set's round-robin pointer rr[index].
- REQ: hold mem_req and mem_address stable. On mem_valid: write {1, latched tag, mem_data} to the victim, clear mem_req, go to FILL.
- FILL: one bubble cycle. Advance rr[index] only if a valid line was replaced. Go to IDLE. The re-presented address then hits.
- mem_valid in IDLE or FILL is ignored; no array write occurs.
- instr_addressIF changing during REQ/FILL does not affect the refill, which uses the latched address.
- flush:
  - In IDLE: clear all valid bits and rr pointers at the edge. A hit in the same cycle still returns data.
  - In REQ/FILL: set flush_pend. The refill completes; flush is applied on the FILL→IDLE edge, so the refilled line is also invalidated.
- WAYS=1: no pointer; the victim is always way 0.

## Timing
- Reset values: instr_out=0, instr_valid=0, mem_req=0, mem_address=0, FSM=IDLE, all valid bits=0, rr=0, flush_pend=0.
- RESET low mid-miss: mem_req=0 after that edge. A later mem_valid is ignored.
- Hit latency: address + fetch_valid in cycle N, instr_out/instr_valid at edge N+1. Back-to-back hits give full throughput.
- Miss: mem_req rises at edge N+1. With mem_valid in cycle M, the array is written and mem_req falls at edge M+1. FILL occupies M+1, IDLE at M+2, and the instruction appears at M+3. Minimum penalty with mem_valid in N+1 is 4 cycles.
- mem_valid coincident with the mem_req-rising cycle is not possible; memory must sample mem_req first.
- instr_valid=0 in any cycle without a hit.

## Structure
- Package icache_pkg: state enum {IDLE, REQ, FILL}; width functions for OFF_W, IDX_W, TAG_W; parameter legality checks.
- Sub-module icache_way_store, instantiated WAYS times. It holds the valid/tag/data arrays per way, with async read, a write port, and a flush-clear input.
- Top level owns the FSM, victim select, rr pointers, and the output mux.

## Test plan
- Cold miss at 0x0000_0044 → mem_address=0x0000_0040. After mem_valid with word1=0xDEADBEEF, instr_out=0xDEADBEEF and instr_valid=1 on the 3rd edge after mem_valid.
- Hit stream 0x40,0x44,...,0x5C after the fill → 8 consecutive instr_valid cycles with stall=0 and no mem_req.
- WAYS=2 conflict: fill 0x0000_0040, 0x0000_8040, 0x0001_0040 (same set) → third fill evicts way 0 (0x40). A refetch of 0x8040 hits; 0x40 misses.
- flush pulsed while in REQ → the fill completes, then a refetch of the same address misses again with mem_req=1.
- RESET low for 1 cycle while in REQ → mem_req=0 next edge. A later mem_valid is ignored, and the next fetch misses.
- mem_valid pulsed while in IDLE with fetch_valid=0 → no state change, no array write; hit stays 0 for that address.
